// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use bubbles, taken-branch flushes
// and multi-cycle MDU sequencing. Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int unsigned MDU_LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] IF_ID_instruction_i,
    input  logic [31:0] ID_EX_instruction_i,
    input  logic        ID_EX_memRead_i,
    input  logic        branch_taken_i,
    output logic        pc_write_o,
    output logic        IF_ID_write_o,
    output logic        IF_ID_flush_o,
    output logic        ID_EX_flush_o,
    output logic        EX_MEM_flush_o,
    output logic        mdu_start_o,
    output logic        mdu_abort_o,
    output logic        mdu_busy_o,
    output logic        mdu_done_o,
    output logic [15:0] stall_cycles_o,
    output logic [15:0] flush_count_o
);

    typedef enum logic [0:0] {StRun, StBusy} state_e;

    localparam logic [3:0] LatCount = 4'(MDU_LATENCY);

    state_e     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic       issued_last_q, issued_last_d;

    logic [5:0] id_op, id_funct;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       is_mdu_op, is_hilo_read, load_use, mdu_stall;
    logic       unused_instr_bits;

    assign id_op    = IF_ID_instruction_i[31:26];
    assign id_funct = IF_ID_instruction_i[5:0];
    assign id_rs    = IF_ID_instruction_i[25:21];
    assign id_rt    = IF_ID_instruction_i[20:16];
    assign ex_rt    = ID_EX_instruction_i[20:16];

    assign unused_instr_bits = ^{IF_ID_instruction_i[15:6], ID_EX_instruction_i[31:21],
                                 ID_EX_instruction_i[15:0]};

    assign is_mdu_op    = (id_op == 6'd0) &&
                          (id_funct == 6'h18 || id_funct == 6'h19 ||
                           id_funct == 6'h1A || id_funct == 6'h1B);
    assign is_hilo_read = (id_op == 6'd0) && (id_funct == 6'h10 || id_funct == 6'h12);

    assign load_use  = ID_EX_memRead_i && (ex_rt != 5'd0) &&
                       ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign mdu_stall = (state_q == StBusy) && (is_mdu_op || is_hilo_read);

    always_comb begin
        pc_write_o     = 1'b1;
        IF_ID_write_o  = 1'b1;
        IF_ID_flush_o  = 1'b0;
        ID_EX_flush_o  = 1'b0;
        EX_MEM_flush_o = 1'b0;
        mdu_start_o    = 1'b0;
        mdu_abort_o    = 1'b0;
        state_d        = state_q;
        count_d        = count_q;
        issued_last_d  = 1'b0;

        if (state_q == StBusy) begin
            count_d = count_q - 4'd1;
            if (count_q == 4'd1) begin
                state_d = StRun;
            end
        end

        // Controls stay at their defaults while reset is held.
        if (!rst_i) begin
            if (branch_taken_i) begin
                IF_ID_flush_o  = 1'b1;
                ID_EX_flush_o  = 1'b1;
                EX_MEM_flush_o = 1'b1;
                // Only an op issued from the flushed path is cancelled.
                if (issued_last_q) begin
                    mdu_abort_o = 1'b1;
                    state_d     = StRun;
                    count_d     = 4'd0;
                end
            end else if (load_use || mdu_stall) begin
                pc_write_o    = 1'b0;
                IF_ID_write_o = 1'b0;
                ID_EX_flush_o = 1'b1;
            end else if (state_q == StRun && is_mdu_op) begin
                mdu_start_o   = 1'b1;
                state_d       = StBusy;
                count_d       = LatCount;
                issued_last_d = 1'b1;
            end
        end
    end

    assign mdu_busy_o = (state_q == StBusy) && !rst_i;
    assign mdu_done_o = mdu_busy_o && (count_q == 4'd1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StRun;
            count_q       <= 4'd0;
            issued_last_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            issued_last_q <= issued_last_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!pc_write_o && stall_cycles_q != 16'hFFFF) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
        if (branch_taken_i && flush_count_q != 16'hFFFF) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cycles_q <= 16'd0;
            flush_count_q  <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
`else
    assign stall_cycles_o = 16'd0;
    assign flush_count_o  = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: expected control vectors are queued as stimulus is
// driven and popped when the outputs are sampled mid-cycle.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_id = 32'd0;
    logic [31:0] id_ex = 32'd0;
    logic        mem_read = 1'b0;
    logic        branch = 1'b0;
    logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
    logic        mdu_start, mdu_abort, mdu_busy, mdu_done;
    logic [15:0] stall_cycles, flush_count;
    logic [8:0]  outs;

    int checks = 0;
    int failures = 0;
    int m_stall = 0;
    int m_flush = 0;
    logic [8:0] sb[$];
    logic [8:0] exp_v;

    // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush, start, abort, busy, done}
    localparam logic [8:0] V_DEF        = 9'b110000000;
    localparam logic [8:0] V_STALL      = 9'b000100000;
    localparam logic [8:0] V_STALL_BUSY = 9'b000100010;
    localparam logic [8:0] V_STALL_DONE = 9'b000100011;
    localparam logic [8:0] V_START      = 9'b110001000;
    localparam logic [8:0] V_BUSY       = 9'b110000010;
    localparam logic [8:0] V_DONE       = 9'b110000011;
    localparam logic [8:0] V_BR         = 9'b111110000;
    localparam logic [8:0] V_BR_ABORT   = 9'b111110110;
    localparam logic [8:0] V_BR_BUSY    = 9'b111110010;

    localparam logic [31:0] NOP     = 32'd0;
    localparam logic [31:0] MULT    = {6'd0, 5'd4, 5'd5, 5'd0, 5'd0, 6'h18};
    localparam logic [31:0] DIVU    = {6'd0, 5'd4, 5'd5, 5'd0, 5'd0, 6'h1B};
    localparam logic [31:0] MFLO    = {6'd0, 5'd0, 5'd0, 5'd6, 5'd0, 6'h12};
    localparam logic [31:0] MFHI    = {6'd0, 5'd0, 5'd0, 5'd6, 5'd0, 6'h10};
    localparam logic [31:0] ADD_DEP = {6'd0, 5'd2, 5'd4, 5'd3, 5'd0, 6'h20};
    localparam logic [31:0] ADD_RT  = {6'd0, 5'd4, 5'd2, 5'd3, 5'd0, 6'h20};
    localparam logic [31:0] ADD_R0  = {6'd0, 5'd0, 5'd4, 5'd3, 5'd0, 6'h20};
    localparam logic [31:0] ADD_IND = {6'd0, 5'd7, 5'd8, 5'd9, 5'd0, 6'h20};
    localparam logic [31:0] LW2     = {6'h23, 5'd29, 5'd2, 16'd0};
    localparam logic [31:0] LW0     = {6'h23, 5'd29, 5'd0, 16'd0};

    hazard_ctrl #(.MDU_LATENCY(4)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .IF_ID_instruction_i (if_id),
        .ID_EX_instruction_i (id_ex),
        .ID_EX_memRead_i     (mem_read),
        .branch_taken_i      (branch),
        .pc_write_o          (pc_write),
        .IF_ID_write_o       (ifid_write),
        .IF_ID_flush_o       (ifid_flush),
        .ID_EX_flush_o       (idex_flush),
        .EX_MEM_flush_o      (exmem_flush),
        .mdu_start_o         (mdu_start),
        .mdu_abort_o         (mdu_abort),
        .mdu_busy_o          (mdu_busy),
        .mdu_done_o          (mdu_done),
        .stall_cycles_o      (stall_cycles),
        .flush_count_o       (flush_count)
    );

    assign outs = {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
                   mdu_start, mdu_abort, mdu_busy, mdu_done};

    always #5 clk = ~clk;

    // Drives one cycle of inputs at the falling edge and queues the expected controls.
    task automatic drive(input logic r, input logic [31:0] id, input logic [31:0] ex,
                         input logic mr, input logic br, input logic [8:0] e);
        @(negedge clk);
        rst = r; if_id = id; id_ex = ex; mem_read = mr; branch = br;
        sb.push_back(e);
        if (r) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if (!e[8]) m_stall++;
            if (br) m_flush++;
        end
    endtask

    task automatic test_reset();
        drive(1'b1, ADD_DEP, LW2, 1'b1, 1'b1, V_DEF);
        #2; exp_v = sb.pop_front(); checks++;
        if (outs !== exp_v) begin
            failures++; $display("FAIL reset_outputs: got %b want %b", outs, exp_v);
        end
        checks++;
        if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles, flush_count);
        end
        drive(1'b0, NOP, NOP, 1'b0, 1'b0, V_DEF);
        #2; exp_v = sb.pop_front(); checks++;
        if (outs !== exp_v) begin
            failures++; $display("FAIL reset_release: got %b want %b", outs, exp_v);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] ids[6];
        logic [31:0] exs[6];
        logic        mrs[6];
        logic [8:0]  es[6];
        ids = '{ADD_DEP, ADD_DEP, ADD_RT, ADD_RT, ADD_R0, ADD_DEP};
        exs = '{LW2, NOP, LW2, NOP, LW0, LW2};
        mrs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        es  = '{V_STALL, V_DEF, V_STALL, V_DEF, V_DEF, V_DEF};
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, ids[i], exs[i], mrs[i], 1'b0, es[i]);
            #2; exp_v = sb.pop_front(); checks++;
            if (outs !== exp_v) begin
                failures++; $display("FAIL load_use[%0d]: got %b want %b", i, outs, exp_v);
            end
        end
    endtask

    task automatic test_mdu_issue();
        logic [31:0] ids[17];
        logic [8:0]  es[17];
        ids = '{MULT, MFLO, MFHI, MFLO, MFLO, MFLO,
                MULT, ADD_IND, MULT, MULT, MULT, DIVU, NOP, NOP, NOP, NOP, NOP};
        es  = '{V_START, V_STALL_BUSY, V_STALL_BUSY, V_STALL_BUSY, V_STALL_DONE, V_DEF,
                V_START, V_BUSY, V_STALL_BUSY, V_STALL_BUSY, V_STALL_DONE, V_START,
                V_BUSY, V_BUSY, V_BUSY, V_DONE, V_DEF};
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, ids[i], NOP, 1'b0, 1'b0, es[i]);
            #2; exp_v = sb.pop_front(); checks++;
            if (outs !== exp_v) begin
                failures++; $display("FAIL mdu_issue[%0d]: got %b want %b", i, outs, exp_v);
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] ids[11];
        logic        brs[11];
        logic [8:0]  es[11];
        ids = '{MULT, NOP, NOP, MULT, NOP, NOP, NOP, NOP, NOP, MULT, NOP};
        brs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        es  = '{V_START, V_BR_ABORT, V_DEF, V_START, V_BUSY, V_BR_BUSY, V_BUSY, V_DONE,
                V_DEF, V_BR, V_DEF};
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, ids[i], NOP, 1'b0, brs[i], es[i]);
            #2; exp_v = sb.pop_front(); checks++;
            if (outs !== exp_v) begin
                failures++; $display("FAIL abort[%0d]: got %b want %b", i, outs, exp_v);
            end
        end
    endtask

    task automatic test_priority();
        logic [31:0] ids[8];
        logic [31:0] exs[8];
        logic        mrs[8];
        logic        brs[8];
        logic [8:0]  es[8];
        ids = '{ADD_DEP, ADD_DEP, MULT, NOP, MFLO, MFLO, MFLO, MFLO};
        exs = '{LW2, NOP, NOP, NOP, NOP, NOP, NOP, NOP};
        mrs = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        brs = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        es  = '{V_BR, V_DEF, V_START, V_BUSY, V_BR_BUSY, V_STALL_BUSY, V_STALL_DONE, V_DEF};
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, ids[i], exs[i], mrs[i], brs[i], es[i]);
            #2; exp_v = sb.pop_front(); checks++;
            if (outs !== exp_v) begin
                failures++; $display("FAIL priority[%0d]: got %b want %b", i, outs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [31:0] ids[6];
        logic [8:0]  es[6];
        ids = '{MULT, NOP, NOP, NOP, NOP, NOP};
        es  = '{V_START, V_BUSY, V_BUSY, V_BUSY, V_DONE, V_DEF};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, ids[i], NOP, 1'b0, 1'b0, es[i]);
            #2; exp_v = sb.pop_front(); checks++;
            if (outs !== exp_v) begin
                failures++; $display("FAIL mid_busy_pre[%0d]: got %b want %b", i, outs, exp_v);
            end
        end
        // Asynchronous assertion between edges, while count is 2.
        #1; rst = 1'b1; sb.push_back(V_DEF); m_stall = 0; m_flush = 0;
        #1; exp_v = sb.pop_front(); checks++;
        if (outs !== exp_v) begin
            failures++; $display("FAIL mid_busy_async: got %b want %b", outs, exp_v);
        end
        drive(1'b1, MULT, LW2, 1'b1, 1'b1, V_DEF);
        #2; exp_v = sb.pop_front(); checks++;
        if (outs !== exp_v) begin
            failures++; $display("FAIL mid_busy_hold: got %b want %b", outs, exp_v);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, ids[i], NOP, 1'b0, 1'b0, es[i]);
            #2; exp_v = sb.pop_front(); checks++;
            if (outs !== exp_v) begin
                failures++; $display("FAIL mid_busy_post[%0d]: got %b want %b", i, outs, exp_v);
            end
        end
    endtask

    task automatic test_perf();
        int exp_stall;
        int exp_flush;
        drive(1'b1, NOP, NOP, 1'b0, 1'b0, V_DEF);
        #2; void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, ADD_DEP, LW2, 1'b1, 1'b0, V_STALL);
            #2; exp_v = sb.pop_front(); checks++;
            if (outs !== exp_v) begin
                failures++; $display("FAIL perf_stall[%0d]: got %b want %b", i, outs, exp_v);
            end
            drive(1'b0, ADD_DEP, NOP, 1'b0, 1'b0, V_DEF);
            #2; void'(sb.pop_front());
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, NOP, NOP, 1'b0, 1'b1, V_BR);
            #2; exp_v = sb.pop_front(); checks++;
            if (outs !== exp_v) begin
                failures++; $display("FAIL perf_branch[%0d]: got %b want %b", i, outs, exp_v);
            end
        end
        drive(1'b0, NOP, NOP, 1'b0, 1'b0, V_DEF);
        #2; void'(sb.pop_front());
        @(negedge clk); #2;
`ifdef HAZARD_PERF_EN
        exp_stall = m_stall;
        exp_flush = m_flush;
`else
        exp_stall = 0;
        exp_flush = 0;
`endif
        checks++;
        if (stall_cycles !== 16'(exp_stall)) begin
            failures++; $display("FAIL perf_stall_count: got %0d want %0d", stall_cycles, exp_stall);
        end
        checks++;
        if (flush_count !== 16'(exp_flush)) begin
            failures++; $display("FAIL perf_flush_count: got %0d want %0d", flush_count, exp_flush);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mdu_issue();
        test_abort();
        test_priority();
        test_reset_mid_busy();
        test_perf();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. Sits beside the forwarding unit and sequences the pipeline registers: inserts the load-use bubble, flushes wrong-path instructions on a taken branch, and owns the multi-cycle multiply/divide unit (MDU), stalling dependent instructions until it finishes. All stall/flush/write-enable controls for PC, IF/ID, ID/EX and EX/MEM come from this block.

## Interface
- MDU_LATENCY, 4, busy cycles per mult/div after issue; legal range 2..15.
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; asynchronous, active-high.
- IF_ID_instruction_i  in  32  instruction in ID stage.
- ID_EX_instruction_i  in  32  instruction in EX stage.
- ID_EX_memRead_i  in  1  EX-stage instruction is a load.
- branch_taken_i  in  1  EX/MEM-stage branch resolved taken this cycle.
- pc_write_o  out  1  PC load enable.
- IF_ID_write_o  out  1  IF/ID register enable.
- IF_ID_flush_o  out  1  zero IF/ID on next edge.
- ID_EX_flush_o  out  1  zero ID/EX control on next edge (bubble).
- EX_MEM_flush_o  out  1  zero EX/MEM control on next edge.
- mdu_start_o  out  1  one-cycle MDU issue pulse.
- mdu_abort_o  out  1  one-cycle MDU cancel pulse.
- mdu_busy_o  out  1  state is BUSY.
- mdu_done_o  out  1  last BUSY cycle.
- stall_cycles_o  out  16  stall-cycle counter (see Configuration).
- flush_count_o  out  16  taken-branch flush counter (see Configuration).

## Operation
- Decodes from IF_ID_instruction_i: MDU op = opcode 0, funct 6'h18/6'h19/6'h1A/6'h1B; HI/LO read = opcode 0, funct 6'h10/6'h12. rs=[25:21], rt=[20:16].
- load_use = ID_EX_memRead_i & ID_EX rt != 0 & (ID_EX rt == IF_ID rs | ID_EX rt == IF_ID rt).
- States: RUN, BUSY. Registered: state, 4-bit count, issued_last flag.
- mdu_stall = state==BUSY & IF_ID holds MDU op or HI/LO read.
- Priority per cycle, highest first:
  - branch_taken_i: pc_write_o=1, IF_ID_flush_o=ID_EX_flush_o=EX_MEM_flush_o=1, no issue; if issued_last, mdu_abort_o=1 and next state RUN, count 0. Otherwise BUSY continues.
  - load_use or mdu_stall: pc_write_o=0, IF_ID_write_o=0, ID_EX_flush_o=1, no issue.
  - RUN & IF_ID MDU op: mdu_start_o=1, pipeline advances; next state BUSY, count=MDU_LATENCY, issued_last=1.
  - else: pc_write_o=IF_ID_write_o=1, all flushes 0.
- BUSY: count decrements each cycle; mdu_done_o=1 when count==1; next state RUN after that cycle. Unrelated instructions flow through during BUSY.
- issued_last is 1 only in the cycle immediately following mdu_start_o; cleared otherwise.
- Non-branch defaults: pc_write_o=IF_ID_write_o=1, flushes 0, pulses 0.

## Timing
- Stall/flush/start outputs combinational from registered state + inputs; take effect at next edge.
- Issue at cycle N; BUSY N+1..N+MDU_LATENCY; mdu_done_o at N+MDU_LATENCY; RUN at N+MDU_LATENCY+1.
- HI/LO read in ID at N+1 stalls through N+MDU_LATENCY, advances at N+MDU_LATENCY+1.
- Load-use: exactly one bubble cycle (condition clears as load leaves EX).
- Reset (async, any time incl. mid-BUSY): state RUN, count 0, issued_last 0, counters 0; while rst_i=1 all outputs forced to defaults (pc_write_o=1, IF_ID_write_o=1, all others 0), branch_taken_i ignored.
- Branch in same cycle as load_use or mdu_stall: branch wins, no stall.
- Branch in same cycle as RUN MDU op in ID: op flushed, not issued.

## Configuration
- HAZARD_PERF_EN defined: stall_cycles_o increments every cycle pc_write_o=0; flush_count_o increments every cycle branch_taken_i=1 (outside reset); both saturate at 16'hFFFF, cleared by reset.
- Undefined: counters not built; stall_cycles_o and flush_count_o tied to 0.

## Test plan
- Load-use: lw $2 in EX (memRead=1, rt=2), add $3,$2,$4 in ID -> one cycle pc_write_o=0, IF_ID_write_o=0, ID_EX_flush_o=1, then normal; rt=0 case -> no stall.
- MDU issue, MDU_LATENCY=4: mult in ID at N -> mdu_start_o at N, mdu_busy_o N+1..N+4, mdu_done_o at N+4; mflo in ID at N+1 stalls 4 cycles; add at N+1 does not stall.
- Abort: branch_taken_i=1 at N+1 after issue -> all three flushes, mdu_abort_o=1, RUN at N+2; branch at N+2 -> no abort, BUSY continues.
- Priority: branch_taken_i with simultaneous load_use -> pc_write_o=1, flushes 1, no stall.
- Reset mid-BUSY (count=2): rst_i async high -> mdu_busy_o=0 immediately, outputs at defaults; after release RUN, mult issues normally.
- HAZARD_PERF_EN: 3 load-use stalls + 2 taken branches -> stall_cycles_o=3, flush_count_o=2; undefined -> both 0.
